// File: rtl/latch_bank_pkg.sv
// Shared definitions for the latch bank write scheduler, the bank and its bench.
// Holds the scheduler state encoding, default sizes and latch-enable levels.
package latch_bank_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      OPEN  = 2'd2,
      CLOSE = 2'd3
   } wr_state_e;

   localparam int DEF_N_REQ   = 4;
   localparam int DEF_N_ENTRY = 8;
   localparam int DEF_DATA_W  = 32;

   localparam logic LE_CLOSED = 1'b0;
   localparam logic LE_OPEN   = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: lowest requesting index at or after ptr,
// wrapping to the lowest requesting index below ptr.
module rr_pick #(
   parameter  int N_REQ = 4,
   localparam int PW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [PW-1:0]    idx
);

   always_comb begin
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int r = 0; r < N_REQ; r++) begin
         if (!found && req[r] && (PW'(r) >= ptr)) begin
            gnt[r] = 1'b1;
            idx    = PW'(r);
            found  = 1'b1;
         end
      end
      // nothing at or above ptr: wrap, so the lowest requester (below ptr) wins
      for (int r = 0; r < N_REQ; r++) begin
         if (!found && req[r]) begin
            gnt[r] = 1'b1;
            idx    = PW'(r);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/latch_bank_wr_sched.sv
// Round-robin write scheduler for a latch bank: one SETUP/OPEN/CLOSE sequence
// per write, with every enable, grant and ack driven straight from a flop.
module latch_bank_wr_sched
   import latch_bank_pkg::*;
#(
   parameter  int N_REQ   = DEF_N_REQ,
   parameter  int N_ENTRY = DEF_N_ENTRY,
   parameter  int DATA_W  = DEF_DATA_W,
   localparam int AW      = $clog2(N_ENTRY)
) (
   input  logic                    i_clk,
   input  logic                    i_arst_n,
   input  logic [N_REQ-1:0]        i_req,
   input  logic [N_REQ*AW-1:0]     i_addr,
   input  logic [N_REQ*DATA_W-1:0] i_wdata,
   output logic [N_REQ-1:0]        o_gnt,
   output logic [N_REQ-1:0]        o_ack,
   output logic                    o_err,
   output logic [N_ENTRY-1:0]      o_le,
   output logic [DATA_W-1:0]       o_ldata,
   output logic                    o_busy
);

   localparam int PW = $clog2(N_REQ);

   wr_state_e          state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d, idx_q, idx_d, pick_idx;
   logic [N_REQ-1:0]   pick_gnt, gnt_q, gnt_d, ack_q, ack_d;
   logic [AW-1:0]      addr_q, addr_d, addr_sel;
   logic [DATA_W-1:0]  data_q, data_d, data_sel;
   logic [N_ENTRY-1:0] le_q, le_d;
   logic               err_q, err_d, busy_q, busy_d, addr_ok;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req (i_req),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   always_comb begin
      addr_sel = '0;
      data_sel = '0;
      for (int r = 0; r < N_REQ; r++) begin
         if (pick_idx == PW'(r)) begin
            addr_sel = i_addr[r*AW +: AW];
            data_sel = i_wdata[r*DATA_W +: DATA_W];
         end
      end
   end

   assign addr_ok = 32'(addr_q) < 32'(N_ENTRY);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      data_d  = data_q;
      gnt_d   = gnt_q;
      busy_d  = busy_q;
      ack_d   = '0;
      err_d   = 1'b0;
      le_d    = {N_ENTRY{LE_CLOSED}};
      unique case (state_q)
         IDLE: begin
            if (|i_req) begin
               state_d = SETUP;
               idx_d   = pick_idx;
               addr_d  = addr_sel;
               data_d  = data_sel;
               gnt_d   = pick_gnt;
               busy_d  = 1'b1;
            end
         end
         SETUP: begin
            // enable decoded a cycle early so the bank sees a clean flop output
            state_d = OPEN;
            for (int e = 0; e < N_ENTRY; e++) begin
               if (32'(addr_q) == 32'(e)) le_d[e] = LE_OPEN;
            end
         end
         OPEN: begin
            state_d = CLOSE;
            ack_d   = gnt_q;
            err_d   = !addr_ok;
         end
         CLOSE: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            ptr_d   = (idx_q == PW'(N_REQ-1)) ? '0 : idx_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         le_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         le_q    <= le_d;
         busy_q  <= busy_d;
      end
   end

   assign o_gnt   = gnt_q;
   assign o_ack   = ack_q;
   assign o_err   = err_q;
   assign o_le    = le_q;
   assign o_ldata = data_q;
   assign o_busy  = busy_q;

endmodule

// File: tb/tb_latch_bank_wr_sched.sv
// Bench for latch_bank_wr_sched: directed scenarios plus random traffic checked
// against a transaction-level model of the write scheduler.
module tb_latch_bank_wr_sched;

   localparam int NR = 4;
   localparam int NE = 6;
   localparam int DW = 32;
   localparam int AW = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [NR-1:0]   req = '0;
   logic [NR*AW-1:0] addr = '0;
   logic [NR*DW-1:0] wdata = '0;
   logic [NR-1:0]   gnt, ack;
   logic            err, busy;
   logic [NE-1:0]   le;
   logic [DW-1:0]   ldata;

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] bank [NE];

   always #5 clk = ~clk;

   // behavioural latch bank fed by the scheduler
   always @(le or ldata) begin
      for (int i = 0; i < NE; i++) if (le[i]) bank[i] = ldata;
   end

   latch_bank_wr_sched #(.N_REQ(NR), .N_ENTRY(NE), .DATA_W(DW)) dut (
      .i_clk   (clk),
      .i_arst_n(rst_n),
      .i_req   (req),
      .i_addr  (addr),
      .i_wdata (wdata),
      .o_gnt   (gnt),
      .o_ack   (ack),
      .o_err   (err),
      .o_le    (le),
      .o_ldata (ldata),
      .o_busy  (busy)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_slot(input int r, input int a, input logic [DW-1:0] d);
      addr[r*AW +: AW]  = AW'(a);
      wdata[r*DW +: DW] = d;
   endtask

   task automatic do_reset();
      req   = '0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      req = 4'b1111;
      tick();
      tick();
      checks++;
      if ({gnt, ack, err, le, busy} !== 16'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0000", {gnt, ack, err, le, busy});
      end
      checks++;
      if (ldata !== '0) begin
         failures++;
         $display("FAIL reset_ldata got=%h exp=0", ldata);
      end
      req = '0;
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if ({gnt, busy} !== 5'h0) begin
         failures++;
         $display("FAIL reset_idle got=%h exp=00", {gnt, busy});
      end
   endtask

   task automatic test_single_write();
      logic [15:0] e;
      set_slot(0, 3, 32'hDEADBEEF);
      req = 4'b0001;
      for (int c = 1; c <= 4; c++) begin
         tick();
         e = {(c < 4) ? 4'b0001 : 4'b0000, (c == 3) ? 4'b0001 : 4'b0000, 1'b0,
              (c == 2) ? 6'b001000 : 6'b000000, c < 4};
         checks++;
         if ({gnt, ack, err, le, busy} !== e) begin
            failures++;
            $display("FAIL single_write_c%0d got=%h exp=%h", c, {gnt, ack, err, le, busy}, e);
         end
         if (c < 4) begin
            checks++;
            if (ldata !== 32'hDEADBEEF) begin
               failures++;
               $display("FAIL single_write_ldata_c%0d got=%h exp=deadbeef", c, ldata);
            end
         end
         if (c == 3) req = '0;
      end
      checks++;
      if (bank[3] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL single_write_bank got=%h exp=deadbeef", bank[3]);
      end
   endtask

   task automatic test_contention();
      int order[$];
      int at[$];
      int exp2[2] = '{0, 2};
      logic [DW-1:0] d[NR];
      do_reset();
      for (int r = 0; r < NR; r++) begin
         d[r] = $urandom;
         set_slot(r, r, d[r]);
      end
      req = 4'b1111;
      for (int c = 0; c < 60 && order.size() < 4; c++) begin
         tick();
         if (ack != '0) begin
            for (int r = 0; r < NR; r++) if (ack[r]) begin
               order.push_back(r);
               at.push_back(c);
            end
            req = req & ~ack;
         end
      end
      checks++;
      if (order.size() != 4) begin
         failures++;
         $display("FAIL contention_count got=%0d exp=4", order.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] != i) begin
               failures++;
               $display("FAIL contention_order_%0d got=%0d exp=%0d", i, order[i], i);
            end
            if (i > 0) begin
               checks++;
               if (at[i] - at[i-1] != 4) begin
                  failures++;
                  $display("FAIL contention_spacing_%0d got=%0d exp=4", i, at[i] - at[i-1]);
               end
            end
         end
      end
      for (int r = 0; r < NR; r++) begin
         checks++;
         if (bank[r] !== d[r]) begin
            failures++;
            $display("FAIL contention_bank_%0d got=%h exp=%h", r, bank[r], d[r]);
         end
      end
      order.delete();
      req = 4'b0101;
      for (int c = 0; c < 30 && order.size() < 2; c++) begin
         tick();
         if (ack != '0) begin
            for (int r = 0; r < NR; r++) if (ack[r]) order.push_back(r);
            req = req & ~ack;
         end
      end
      checks++;
      if (order.size() != 2) begin
         failures++;
         $display("FAIL contention2_count got=%0d exp=2", order.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (order[i] != exp2[i]) begin
               failures++;
               $display("FAIL contention2_order_%0d got=%0d exp=%0d", i, order[i], exp2[i]);
            end
         end
      end
      req = '0;
      tick();
   endtask

   task automatic test_out_of_range();
      int tbl[3] = '{5, 6, 7};
      logic [15:0] e;
      logic [NE-1:0] el;
      for (int t = 0; t < 3; t++) begin
         set_slot(1, tbl[t], $urandom);
         req = 4'b0010;
         for (int c = 1; c <= 4; c++) begin
            tick();
            el = (c == 2 && tbl[t] < NE) ? (NE'(1) << tbl[t]) : '0;
            e = {(c < 4) ? 4'b0010 : 4'b0000, (c == 3) ? 4'b0010 : 4'b0000,
                 (c == 3) && (tbl[t] >= NE), el, c < 4};
            checks++;
            if ({gnt, ack, err, le, busy} !== e) begin
               failures++;
               $display("FAIL range_a%0d_c%0d got=%h exp=%h", tbl[t], c, {gnt, ack, err, le, busy}, e);
            end
            if (c == 3) req = '0;
         end
      end
   endtask

   task automatic test_disturbance();
      logic [DW-1:0] da, db, old5;
      da = $urandom;
      db = ~da;
      old5 = bank[5];
      set_slot(3, 2, da);
      req = 4'b1000;
      tick();
      checks++;
      if (gnt !== 4'b1000) begin
         failures++;
         $display("FAIL disturb_gnt got=%b exp=1000", gnt);
      end
      set_slot(3, 5, db);
      req = '0;
      tick();
      checks++;
      if (le !== 6'b000100 || ldata !== da) begin
         failures++;
         $display("FAIL disturb_open got le=%b d=%h exp le=000100 d=%h", le, ldata, da);
      end
      tick();
      checks++;
      if (ack !== 4'b1000 || ldata !== da || le !== '0) begin
         failures++;
         $display("FAIL disturb_close got ack=%b d=%h le=%b exp ack=1000 d=%h", ack, ldata, le, da);
      end
      tick();
      checks++;
      if (bank[2] !== da || bank[5] !== old5 || busy !== 1'b0) begin
         failures++;
         $display("FAIL disturb_bank got b2=%h b5=%h busy=%b exp b2=%h b5=%h", bank[2], bank[5], busy, da, old5);
      end
   endtask

   task automatic test_reset_mid_open();
      set_slot(2, 0, $urandom);
      req = 4'b0100;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 3) begin
            checks++;
            if (ack !== 4'b0100) begin
               failures++;
               $display("FAIL midrst_pre_ack got=%b exp=0100", ack);
            end
            req = '0;
         end
      end
      set_slot(2, 5, $urandom);
      req = 4'b0100;
      tick();
      tick();
      checks++;
      if (le !== 6'b100000) begin
         failures++;
         $display("FAIL midrst_open_le got=%b exp=100000", le);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({gnt, ack, err, le, busy} !== 16'h0 || ldata !== '0) begin
         failures++;
         $display("FAIL midrst_async got=%h d=%h exp=0000 d=0", {gnt, ack, err, le, busy}, ldata);
      end
      req = '0;
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || ack !== '0) begin
         failures++;
         $display("FAIL midrst_idle got busy=%b ack=%b exp busy=0 ack=0000", busy, ack);
      end
      set_slot(0, 1, $urandom);
      set_slot(3, 4, $urandom);
      req = 4'b1001;
      tick();
      checks++;
      if (gnt !== 4'b0001) begin
         failures++;
         $display("FAIL midrst_ptr got=%b exp=0001", gnt);
      end
      tick();
      tick();
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_random();
      int age = 0, win = 0, ptr = 0, le_cnt = 0;
      logic [AW-1:0] maddr = '0;
      logic [DW-1:0] mdata = '0;
      logic [NR-1:0] pend = '0, e_gnt, e_ack;
      logic [NE-1:0] e_le;
      logic e_err;
      logic [15:0] e;
      do_reset();
      for (int cyc = 0; cyc < 10000; cyc++) begin
         e_gnt = (age != 0) ? (NR'(1) << win) : '0;
         e_ack = (age == 3) ? (NR'(1) << win) : '0;
         e_le  = (age == 2 && maddr < NE) ? (NE'(1) << maddr) : '0;
         e_err = (age == 3) && (maddr >= NE);
         e = {e_gnt, e_ack, e_err, e_le, age != 0};
         checks++;
         if ({gnt, ack, err, le, busy} !== e) begin
            failures++;
            $display("FAIL random_c%0d got=%h exp=%h", cyc, {gnt, ack, err, le, busy}, e);
         end
         checks++;
         if (ldata !== mdata) begin
            failures++;
            $display("FAIL random_ldata_c%0d got=%h exp=%h", cyc, ldata, mdata);
         end
         checks++;
         if (!$onehot0(le) || !$onehot0(ack)) begin
            failures++;
            $display("FAIL random_onehot_c%0d got le=%b ack=%b exp at most one bit each", cyc, le, ack);
         end
         if (le != '0) le_cnt++;
         if (ack != '0) begin
            checks++;
            if (le_cnt != (e_err ? 0 : 1)) begin
               failures++;
               $display("FAIL random_le_per_ack_c%0d got=%0d exp=%0d", cyc, le_cnt, e_err ? 0 : 1);
            end
            le_cnt = 0;
         end
         for (int r = 0; r < NR; r++) begin
            if (pend[r] && e_ack[r]) pend[r] = 1'($urandom_range(0, 1));
            else if (!pend[r]) pend[r] = ($urandom_range(0, 3) == 0);
            addr[r*AW +: AW]  = AW'($urandom_range(0, 7));
            wdata[r*DW +: DW] = $urandom;
         end
         req = pend;
         if (age == 0) begin
            if (req != '0) begin
               for (int k = 0; k < NR; k++) begin
                  if (req[(ptr + k) % NR]) begin
                     win = (ptr + k) % NR;
                     break;
                  end
               end
               maddr = addr[win*AW +: AW];
               mdata = wdata[win*DW +: DW];
               age = 1;
            end
         end else if (age == 3) begin
            age = 0;
            ptr = (win + 1) % NR;
         end else begin
            age++;
         end
         tick();
      end
      req = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_write();
      test_contention();
      test_out_of_range();
      test_disturbance();
      test_reset_mid_open();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/latch_bank_wr_sched.md
# latch_bank_wr_sched

Write scheduler for a latch-based storage bank, i.e. an array of level-sensitive entries each written by an `always_latch` process. Arbitrates write requests from `N_REQ` requesters round-robin and runs one glitch-free setup/open/close sequence per write on the selected entry's latch enable. Sits between the requesters and the latch bank; the bank itself is a separate module.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `N_ENTRY`, 8: number of latch entries, ≥2, not necessarily a power of two.
- `DATA_W`, 32: entry width.
- `AW`, `$clog2(N_ENTRY)`: address width, derived; not overridden.
- `i_clk`  input  1  clock.
- `i_arst_n`  input  1  reset, asynchronous, active-low.
- `i_req`  input  N_REQ  write request per requester, level; held until its `o_ack`.
- `i_addr`  input  N_REQ*AW  packed entry address per requester.
- `i_wdata`  input  N_REQ*DATA_W  packed write data per requester.
- `o_gnt`  output  N_REQ  one-hot grant, high from SETUP through CLOSE.
- `o_ack`  output  N_REQ  one-hot completion pulse, one cycle.
- `o_err`  output  1  pulse with `o_ack` when the address was ≥ N_ENTRY.
- `o_le`  output  N_ENTRY  latch enables to the bank, at most one high.
- `o_ldata`  output  DATA_W  data to the bank.
- `o_busy`  output  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, SETUP, OPEN, CLOSE.
- IDLE: if any `i_req` is high, pick the winner round-robin starting at `rr_ptr`. Register the winner index, `i_addr` slice, and `i_wdata` slice. Go to SETUP. Otherwise stay.
- SETUP: `o_ldata` shows the captured data, `o_le` is all zero. Go to OPEN.
- OPEN: `o_le[addr]` = 1 if addr < N_ENTRY; otherwise `o_le` stays zero and an error flag is set. Go to CLOSE.
- CLOSE: `o_le` is zero and `o_ldata` is still held (hold time). `o_ack[winner]` = 1, plus `o_err` if the error flag is set. Set `rr_ptr` = (winner+1) mod N_REQ. Go to IDLE.
- Captured address and data are frozen from SETUP to CLOSE. Input changes and a dropped `i_req` mid-transaction are ignored, and the transaction completes.
- A requester whose `i_req` is still high in the IDLE cycle right after its `o_ack` is treated as a new request.
- `o_le`, `o_ack`, `o_err`, and `o_gnt` come directly from flops, with no combinational decode after a flop. This keeps the latch enables glitch-free.
- Reset values: state IDLE, `rr_ptr` 0, and all outputs 0 (`o_gnt`, `o_ack`, `o_err`, `o_le`, `o_ldata`, `o_busy`).
- Reset asserted mid-sequence forces `o_le` to 0 immediately (asynchronously), with no ack. The interrupted requester re-requests after reset.

## Timing
- Request seen high at edge T0 in IDLE:
  - SETUP in cycle T0+1.
  - `o_le` high for exactly cycle T0+2.
  - `o_ack` in cycle T0+3.
  - Back in IDLE at T0+4.
- Throughput: one write per 4 cycles; the IDLE cycle is mandatory between transactions.
- `o_ldata` is stable for one cycle before, during, and one cycle after `o_le`.
- Simultaneous requests: the lowest index at or after `rr_ptr` wins, wrapping modulo N_REQ.

## Structure
- Shared package `latch_bank_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, SETUP, OPEN, CLOSE} wr_state_e`;
  - default parameter constants;
  - `localparam` encodings reused by the bank and its bench.
- One sub-module: `rr_pick`, a combinational round-robin priority selector. Inputs: request vector and pointer. Outputs: one-hot grant and binary index. Parameterised by N_REQ.
- The FSM, capture registers, and enable decode flop stay in the top module.

## Test plan
- Single write: req0, addr 3, data 0xDEADBEEF at T0 → `o_le[3]` high only at T0+2, `o_ldata` = 0xDEADBEEF over T0+1..T0+3, `o_ack[0]` at T0+3. The bank entry 3 reads 0xDEADBEEF.
- Contention: req0..req3 all high and held through their acks → grants in order 0,1,2,3, acks 4 cycles apart. Then with `rr_ptr` = 0, only req2 and req0 re-asserted → 0 then 2.
- Out-of-range write: N_ENTRY = 6, addr 7 → `o_le` stays 0 throughout, `o_ack` and `o_err` both pulse at T0+3.
- Input disturbance: change `i_wdata` and `i_addr`, and drop `i_req`, during SETUP → the captured values are written and the ack still issues.
- Reset mid-OPEN: assert `i_arst_n` = 0 between edges while `o_le[5]` = 1 → `o_le` goes to 0 without waiting for a clock edge, all outputs go to 0, and after release the FSM is in IDLE with `rr_ptr` = 0.
- Enable exclusivity: random traffic for 10k cycles → `$onehot0(o_le)`, `$onehot0(o_ack)`, and `o_le` high for 1 cycle per ack every cycle.
